// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the E stage.
// Timed ops latch operands, count out a fixed latency, then commit the result to HI/LO.
module md_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned DW      = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [DW-1:0]    base_q, base_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;

    logic [DW-1:0]    prod_s, prod_u, res;
    logic [WIDTH-1:0] mag_a, mag_b, q_u, r_u, quot, rem;
    logic             sgn_div;
    logic [CNT_W-1:0] limit;

    // Result from latched operands; signed divide via magnitudes so MIN/-1 wraps back to MIN.
    always_comb begin
        prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u  = DW'(a_q) * DW'(b_q);
        sgn_div = (op_q == OP_DIV);
        mag_a   = (sgn_div && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b   = (sgn_div && b_q[WIDTH-1]) ? -b_q : b_q;
        q_u     = mag_a / mag_b;
        r_u     = mag_a % mag_b;
        quot    = (sgn_div && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -q_u : q_u;
        rem     = (sgn_div && a_q[WIDTH-1]) ? -r_u : r_u;
        case (op_q)
            OP_MULT:          res = prod_s;
            OP_MULTU:         res = prod_u;
            OP_MADD:          res = base_q + prod_s;
            OP_MADDU:         res = base_q + prod_u;
            OP_MSUB:          res = base_q - prod_s;
            OP_MSUBU:         res = base_q - prod_u;
            OP_DIV, OP_DIVU:  res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quot};
            default:          res = base_q;
        endcase
        limit = (op_q == OP_DIV || op_q == OP_DIVU) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end

    // Next-state: accept in IDLE, count out latency in BUSY; flush beats commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        base_d  = base_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_W'(1);
                            op_d    = op;
                            a_d     = a;
                            b_d     = b;
                            base_d  = {hi_q, lo_q};
                        end
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == limit) begin
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                    hi_d       = res[DW-1:WIDTH];
                    lo_d       = res[WIDTH-1:0];
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            base_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            base_q  <= base_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
